multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control unit of the multicycle MIPS processor; sits beside the datapath inside the processor top and produces every enable/select that datapath and unified memory consume.
- Drives the memwrite strobe that the system bench samples.
- Moore main FSM (one instruction step per clock) plus a combinational ALU decoder sub-module.
- Supports lw, sw, R-type (add, sub, and, or, slt), beq, addi, j.

Parameters:
- none (ISA fixed; encodings live in shared package)

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high; forces FETCH
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag, same cycle
- pcen  out  1  PC load enable = pcwrite | (branch & zero)
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  out  1  write-back select: 1 = memory data register
- regdst  out  1  destination select: 1 = rd, 0 = rt
- alusrca  out  1  ALU A: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU operation

Behaviour:
- Reset: clk and reset as named; reset is asynchronous, active-high; state <= FETCH immediately on assertion.
- While reset high: pcen, memwrite, irwrite, regwrite forced 0; selects carry FETCH values.
- Reset mid-instruction: in-flight instruction abandoned; no partial write after deassertion.
- First rising edge after deassertion executes FETCH.
- Outputs decoded from current state only (Moore). Exception: pcen also depends on combinational zero.
- Every enable not listed for a state is 0.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1 -> DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - lw 100011, sw 101011 -> MEMADR
  - R-type 000000 -> RTYPEEX
  - beq 000100 -> BEQEX
  - addi 001000 -> ADDIEX
  - j 000010 -> JEX
  - any other op -> FETCH (executes as nop, no writes)
- MEMADR: alusrca=1, alusrcb=10, aluop=00 -> MEMRD if lw, MEMWR if sw.
- MEMRD: iord=1 -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1 -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10 -> RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JEX: pcsrc=10, pcwrite=1 -> FETCH.
- Instruction latencies in clocks: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported 2.
- memwrite is high for exactly one cycle per sw and never otherwise.
- ALU decoder:
  - aluop 00 -> 010 (add)
  - aluop 01 -> 110 (sub)
  - aluop 10 -> by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other -> 010
  - aluop 11 -> 010
- Illegal state encodings -> FETCH next cycle.

Decomposition:
- Shared package: 4-bit state encodings FETCH=0 through JEX=11, opcode constants, funct constants, alucontrol codes, aluop codes.
- One sub-module alu_decoder (aluop, funct -> alucontrol), purely combinational.
- FSM state register and output decode stay in multicycle_controller.

Test Plan:
- Hold reset 11 ns, release; op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 clocks; MEMWB regwrite=1, memtoreg=1, regdst=0; memwrite=0 throughout.
- op=101011 -> 4 clocks; memwrite=1 and iord=1 only in MEMWR; regwrite never 1.
- op=000000, funct=101010 -> RTYPEEX alucontrol=111, alusrcb=00; RTYPEWB regdst=1, regwrite=1. Repeat with funct=100010 -> 110.
- op=000100: zero=1 in BEQEX -> pcen=1, pcsrc=01, alucontrol=110; zero=0 -> pcen=0; next state FETCH either way.
- op=111111 -> DECODE returns to FETCH; no write enables; pcen=1 only in FETCH.
- Assert reset asynchronously mid-MEMWR of a sw -> memwrite drops to 0 before next edge, state FETCH; after release a fresh fetch occurs with no spurious write.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// Holds the FSM state codes, the opcode and funct values the controller
// decodes, the internal ALU-op class and the ALU control codes that the
// datapath ALU understands.
package multicycle_controller_pkg;

    typedef logic [3:0] state_t;

    // Main FSM states (4-bit, legacy numbering)
    localparam state_t S_FETCH   = 4'd0;
    localparam state_t S_DECODE  = 4'd1;
    localparam state_t S_MEMADR  = 4'd2;
    localparam state_t S_MEMRD   = 4'd3;
    localparam state_t S_MEMWB   = 4'd4;
    localparam state_t S_MEMWR   = 4'd5;
    localparam state_t S_RTYPEEX = 4'd6;
    localparam state_t S_RTYPEWB = 4'd7;
    localparam state_t S_BEQEX   = 4'd8;
    localparam state_t S_ADDIEX  = 4'd9;
    localparam state_t S_ADDIWB  = 4'd10;
    localparam state_t S_JEX     = 4'd11;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation class from the main FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the datapath/memory.
//   master : controller side - drives every enable/select, receives the
//            instruction fields and the ALU zero flag.
//   slave  : datapath side - the mirror image.
// Signals: op[5:0], funct[5:0], zero (datapath -> controller);
//          pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
//          alusrca, alusrcb[1:0], pcsrc[1:0], alucontrol[2:0]
//          (controller -> datapath).
interface multicycle_controller_if;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;

    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol
    );

    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: purely combinational translation of the FSM's ALU-op class
// and the instruction funct field into the ALU control code.
// Ports:
//   aluop[1:0]      in  : 00 add, 01 sub, 10 decode funct, 11 add
//   funct[5:0]      in  : instr[5:0]
//   alucontrol[2:0] out : ALU operation
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control unit of the multicycle MIPS processor: a Moore FSM stepping one
// instruction phase per clock plus the ALU decoder.
// Ports:
//   clk   in : system clock, rising edge
//   reset in : asynchronous active-high; forces FETCH
//   bus      : multicycle_controller_if.master - op/funct/zero in,
//              all datapath/memory enables and selects out
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    multicycle_controller_if.master        bus
);

    state_t     state;
    state_t     nextstate;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
    logic       irwrite_s;
    logic       regwrite_s;
    logic       memwrite_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= nextstate;
    end

    always_comb begin
        nextstate = S_FETCH;
        case (state)
            S_FETCH:  nextstate = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: nextstate = S_MEMADR;
                    OP_RTYPE:     nextstate = S_RTYPEEX;
                    OP_BEQ:       nextstate = S_BEQEX;
                    OP_ADDI:      nextstate = S_ADDIEX;
                    OP_J:         nextstate = S_JEX;
                    default:      nextstate = S_FETCH;
                endcase
            end
            S_MEMADR:  nextstate = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   nextstate = S_MEMWB;
            S_RTYPEEX: nextstate = S_RTYPEWB;
            S_ADDIEX:  nextstate = S_ADDIWB;
            default:   nextstate = S_FETCH;
        endcase
    end

    // Moore output decode; anything not set by a state stays 0.
    always_comb begin
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite_s    = 1'b0;
        regwrite_s   = 1'b0;
        memwrite_s   = 1'b0;
        bus.iord     = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regdst   = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsrc    = 2'b00;
        aluop        = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                bus.alusrcb = 2'b01;
                irwrite_s   = 1'b1;
                pcwrite     = 1'b1;
            end
            S_DECODE: bus.alusrcb = 2'b11;
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEMRD: bus.iord = 1'b1;
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                regwrite_s   = 1'b1;
            end
            S_MEMWR: begin
                bus.iord   = 1'b1;
                memwrite_s = 1'b1;
            end
            S_RTYPEEX: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                bus.regdst = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BEQEX: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_SUB;
                bus.pcsrc   = 2'b01;
                branch      = 1'b1;
            end
            S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_ADDIWB: regwrite_s = 1'b1;
            S_JEX: begin
                bus.pcsrc = 2'b10;
                pcwrite   = 1'b1;
            end
            default: ;
        endcase
    end

    // State is already FETCH while reset is high, so the selects show FETCH
    // values; only the enables need masking to suppress FETCH's writes.
    assign bus.pcen     = (pcwrite | (branch & bus.zero)) & ~reset;
    assign bus.irwrite  = irwrite_s & ~reset;
    assign bus.regwrite = regwrite_s & ~reset;
    assign bus.memwrite = memwrite_s & ~reset;

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (bus.funct),
        .alucontrol (bus.alucontrol)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Stimulus pushes a hand-written
// expected output pattern per cycle; a monitor pops and compares at the
// falling edge (or on an explicit sample event for asynchronous checks).
// Pattern field order:
//   pcen memwrite irwrite regwrite _ iord memtoreg regdst alusrca _
//   alusrcb _ pcsrc _ alucontrol      ('-' = not checked, '_' ignored)
module tb_multicycle_controller;

    logic clk;
    logic reset;
    logic hold_rst;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    string        name_q[$];
    logic [14:0]  val_q[$];
    logic [14:0]  msk_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    event         sample_now;

    localparam string P_RESET  = "0000_0--0_01_00_010";
    localparam string P_FETCH  = "1010_0--0_01_00_010";
    localparam string P_DECODE = "0000_---0_11_--_010";
    localparam string P_MEMADR = "0000_---1_10_--_010";
    localparam string P_MEMRD  = "0000_1---_--_--_---";
    localparam string P_MEMWB  = "0001_-10-_--_--_---";
    localparam string P_MEMWR  = "0100_1---_--_--_---";
    localparam string P_RTWB   = "0001_-01-_--_--_---";
    localparam string P_BEQ_T  = "1000_---1_00_01_110";
    localparam string P_BEQ_N  = "0000_---1_00_01_110";
    localparam string P_ADDIEX = "0000_---1_10_--_010";
    localparam string P_ADDIWB = "0001_-00-_--_--_---";
    localparam string P_JEX    = "1000_----_--_10_---";

    function automatic void parse(input string p, output logic [14:0] v,
                                  output logic [14:0] m);
        int b;
        v = '0;
        m = '0;
        b = 14;
        for (int i = 0; i < p.len(); i++) begin
            byte c;
            c = p[i];
            if (c != "_" && b >= 0) begin
                if (c == "1") begin
                    v[b] = 1'b1;
                    m[b] = 1'b1;
                end else if (c == "0") begin
                    m[b] = 1'b1;
                end
                b--;
            end
        end
    endfunction

    task automatic push(input string name, input string pat);
        logic [14:0] v;
        logic [14:0] m;
        parse(pat, v, m);
        name_q.push_back(name);
        val_q.push_back(v);
        msk_q.push_back(m);
    endtask

    task automatic step(input string name, input logic [5:0] o,
                        input logic [5:0] f, input logic z, input string pat);
        @(posedge clk);
        #1;
        reset     = hold_rst;
        bus.op    = o;
        bus.funct = f;
        bus.zero  = z;
        push(name, pat);
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk or sample_now);
            if (name_q.size() > 0) begin
                string       nm;
                logic [14:0] v;
                logic [14:0] m;
                logic [14:0] act;
                nm  = name_q.pop_front();
                v   = val_q.pop_front();
                m   = msk_q.pop_front();
                act = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite,
                       bus.iord, bus.memtoreg, bus.regdst, bus.alusrca,
                       bus.alusrcb, bus.pcsrc, bus.alucontrol};
                n_checks++;
                if ((act & m) !== (v & m)) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got %b required %b (mask %b)",
                             nm, $time, act, v, m);
                end
            end
        end
    end

    logic [5:0] fn_tab [6];
    logic [2:0] ac_tab [6];

    initial begin
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        ac_tab = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};

        reset     = 1'b1;
        hold_rst  = 1'b0;
        bus.op    = 6'b0;
        bus.funct = 6'b0;
        bus.zero  = 1'b0;
        push("reset_held", P_RESET);

        // lw: first step releases reset at 11 ns
        step("lw_fetch",  6'b100011, 6'b0, 1'b0, P_FETCH);
        step("lw_decode", 6'b100011, 6'b0, 1'b0, P_DECODE);
        step("lw_memadr", 6'b100011, 6'b0, 1'b0, P_MEMADR);
        step("lw_memrd",  6'b100011, 6'b0, 1'b0, P_MEMRD);
        step("lw_memwb",  6'b100011, 6'b0, 1'b0, P_MEMWB);

        // sw
        step("sw_fetch",  6'b101011, 6'b0, 1'b0, P_FETCH);
        step("sw_decode", 6'b101011, 6'b0, 1'b0, P_DECODE);
        step("sw_memadr", 6'b101011, 6'b0, 1'b0, P_MEMADR);
        step("sw_memwr",  6'b101011, 6'b0, 1'b0, P_MEMWR);

        // R-type over every funct incl. an unknown one
        for (int i = 0; i < 6; i++) begin
            step("rt_fetch",  6'b000000, fn_tab[i], 1'b0, P_FETCH);
            step("rt_decode", 6'b000000, fn_tab[i], 1'b0, P_DECODE);
            step("rt_ex",     6'b000000, fn_tab[i], 1'b0,
                 {"0000_---1_00_--_", $sformatf("%b", ac_tab[i])});
            step("rt_wb",     6'b000000, fn_tab[i], 1'b0, P_RTWB);
        end

        // beq taken then not taken; zero high in DECODE must not raise pcen
        step("beqt_fetch",  6'b000100, 6'b0, 1'b1, P_FETCH);
        step("beqt_decode", 6'b000100, 6'b0, 1'b1, P_DECODE);
        step("beqt_ex",     6'b000100, 6'b0, 1'b1, P_BEQ_T);
        step("beqn_fetch",  6'b000100, 6'b0, 1'b0, P_FETCH);
        step("beqn_decode", 6'b000100, 6'b0, 1'b0, P_DECODE);
        step("beqn_ex",     6'b000100, 6'b0, 1'b0, P_BEQ_N);

        // unsupported opcode: two-cycle nop
        step("nop_fetch",  6'b111111, 6'b0, 1'b1, P_FETCH);
        step("nop_decode", 6'b111111, 6'b0, 1'b1, P_DECODE);

        // addi
        step("addi_fetch",  6'b001000, 6'b0, 1'b1, P_FETCH);
        step("addi_decode", 6'b001000, 6'b0, 1'b1, P_DECODE);
        step("addi_ex",     6'b001000, 6'b0, 1'b1, P_ADDIEX);
        step("addi_wb",     6'b001000, 6'b0, 1'b1, P_ADDIWB);

        // j
        step("j_fetch",  6'b000010, 6'b0, 1'b0, P_FETCH);
        step("j_decode", 6'b000010, 6'b0, 1'b0, P_DECODE);
        step("j_ex",     6'b000010, 6'b0, 1'b0, P_JEX);

        // sw interrupted by asynchronous reset in MEMWR
        step("swr_fetch",  6'b101011, 6'b0, 1'b0, P_FETCH);
        step("swr_decode", 6'b101011, 6'b0, 1'b0, P_DECODE);
        step("swr_memadr", 6'b101011, 6'b0, 1'b0, P_MEMADR);
        step("swr_memwr",  6'b101011, 6'b0, 1'b0, P_MEMWR);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        push("swr_async_reset", P_RESET);
        ->sample_now;
        hold_rst = 1'b1;
        step("swr_reset_hold", 6'b111111, 6'b0, 1'b0, P_RESET);
        hold_rst = 1'b0;
        step("post_fetch",  6'b111111, 6'b0, 1'b0, P_FETCH);
        step("post_decode", 6'b111111, 6'b0, 1'b0, P_DECODE);
        step("post_fetch2", 6'b111111, 6'b0, 1'b0, P_FETCH);

        @(negedge clk);
        #1;
        n_checks++;
        if (name_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", name_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
